// File: rtl/regfile_write_initiator.sv
// Register-file write-port initiator: merges ALU and load results through an in-order FIFO.
// Optional pending-write hazard mask is built only when WB_BUSY_MASK_EN is defined.
module regfile_write_initiator #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     Clk,
    input  logic                     resetControl_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     mem_ready,
    output logic                     we,
    output logic [4:0]               rd,
    output logic [DATA_W-1:0]        in,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  free_c;
    logic [4:0]        rd_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              mem_push_c, alu_push_c, pop_c;
    logic [PTR_W-1:0]  alu_slot_c;
    logic              we_q, we_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] in_q, in_d;

    assign free_c = CNT_W'(DEPTH) - count_q;
    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign we     = we_q;
    assign rd     = rd_q;
    assign in     = in_q;

    // Readiness looks only at room left at cycle start; the load path has priority.
    assign mem_ready = resetControl_n && (free_c >= CNT_W'(1));
    assign alu_ready = resetControl_n &&
                       ((free_c >= CNT_W'(2)) || ((free_c >= CNT_W'(1)) && !mem_valid));

    always_comb begin
        mem_push_c = mem_valid && mem_ready && (mem_rd != 5'd0);
        alu_push_c = alu_valid && alu_ready && (alu_rd != 5'd0);
        pop_c      = !empty;
        alu_slot_c = wr_ptr_q + PTR_W'(mem_push_c);
        wr_ptr_d   = wr_ptr_q + PTR_W'(mem_push_c) + PTR_W'(alu_push_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        count_d    = count_q + CNT_W'(mem_push_c) + CNT_W'(alu_push_c) - CNT_W'(pop_c);
        we_d       = pop_c;
        rd_d       = rd_q;
        in_d       = in_q;
        if (pop_c) begin
            rd_d = rd_mem_q[rd_ptr_q];
            in_d = data_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge Clk) begin
        if (!resetControl_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            rd_q     <= '0;
            in_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            rd_q     <= rd_d;
            in_q     <= in_d;
        end
    end

    // Entry storage needs no reset; occupancy alone defines which slots are live.
    always_ff @(posedge Clk) begin
        if (mem_push_c) begin
            rd_mem_q[wr_ptr_q]   <= mem_rd;
            data_mem_q[wr_ptr_q] <= mem_data;
        end
        if (alu_push_c) begin
            rd_mem_q[alu_slot_c]   <= alu_rd;
            data_mem_q[alu_slot_c] <= alu_data;
        end
    end

`ifdef WB_BUSY_MASK_EN
    logic [PTR_W-1:0] offs_c;

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        busy_mask = '0;
        offs_c    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs_c = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(offs_c) < count_q) begin
                busy_mask[rd_mem_q[PTR_W'(i)]] = 1'b1;
            end
        end
        if (we_q) begin
            busy_mask[rd_q] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end
`else
    assign busy_mask = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_write_initiator.sv
// Directed bench for regfile_write_initiator: vector table on a DEPTH=4 instance plus a
// hand-written full/one-free-slot sequence on a DEPTH=2 instance.
module tb_regfile_write_initiator;
    logic        Clk;
    logic        rst_n;
    logic        av, mv, ar, mr, we_o;
    logic [4:0]  ard, mrd, rd_o;
    logic [31:0] adat, mdat, in_o, busy_o;
    logic [2:0]  cnt_o;
    logic        full_o, empty_o;

    logic        d2_rst_n, d2_av, d2_mv, d2_ar, d2_mr, d2_we;
    logic [4:0]  d2_ard, d2_mrd, d2_rd;
    logic [31:0] d2_adat, d2_mdat, d2_in, d2_busy;
    logic [1:0]  d2_cnt;
    logic        d2_full, d2_empty;

    int checks = 0;
    int errors = 0;
    int cur    = 0;

    regfile_write_initiator #(.DEPTH(4), .DATA_W(32)) u_dut (
        .Clk(Clk), .resetControl_n(rst_n),
        .alu_valid(av), .alu_rd(ard), .alu_data(adat), .alu_ready(ar),
        .mem_valid(mv), .mem_rd(mrd), .mem_data(mdat), .mem_ready(mr),
        .we(we_o), .rd(rd_o), .in(in_o), .busy_mask(busy_o),
        .count(cnt_o), .full(full_o), .empty(empty_o)
    );

    regfile_write_initiator #(.DEPTH(2), .DATA_W(32)) u_d2 (
        .Clk(Clk), .resetControl_n(d2_rst_n),
        .alu_valid(d2_av), .alu_rd(d2_ard), .alu_data(d2_adat), .alu_ready(d2_ar),
        .mem_valid(d2_mv), .mem_rd(d2_mrd), .mem_data(d2_mdat), .mem_ready(d2_mr),
        .we(d2_we), .rd(d2_rd), .in(d2_in), .busy_mask(d2_busy),
        .count(d2_cnt), .full(d2_full), .empty(d2_empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_in;
        logic [2:0]  e_cnt;
        logic [31:0] e_busy;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t v(input int r, input int a_v, input int a_rd, input int a_d,
                               input int m_v, input int m_rd, input int m_d,
                               input int x_ar, input int x_mr, input int x_we, input int x_rd,
                               input int x_in, input int x_cnt, input int x_busy);
        vec_t t;
        t.rst_n = 1'(r);     t.av = 1'(a_v);     t.ard = 5'(a_rd);   t.adat = 32'(a_d);
        t.mv = 1'(m_v);      t.mrd = 5'(m_rd);   t.mdat = 32'(m_d);
        t.e_ar = 1'(x_ar);   t.e_mr = 1'(x_mr);  t.e_we = 1'(x_we);  t.e_rd = 5'(x_rd);
        t.e_in = 32'(x_in);  t.e_cnt = 3'(x_cnt); t.e_busy = 32'(x_busy);
        return t;
    endfunction

    // The mask is only tracked when the feature is compiled in.
    function automatic logic [31:0] bm(input logic [31:0] x);
`ifdef WB_BUSY_MASK_EN
        return x;
`else
        return 32'h0 & x;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", name, cur, act, exp);
        end
    endtask

    task automatic d2_drive(input logic m_v, input int m_rd, input logic a_v, input int a_rd);
        d2_mv = m_v; d2_mrd = 5'(m_rd); d2_mdat = 32'(m_rd);
        d2_av = a_v; d2_ard = 5'(a_rd); d2_adat = 32'(a_rd);
    endtask

    initial begin
        //                r av ard adat          mv mrd mdat  ar mr we rd in            cnt busy
        vecs[0]  = v(0, 0, 0,  0,            0, 0,  0,    0, 0, 0, 0,  0,            0, 0);
        vecs[1]  = v(0, 1, 9,  9,            1, 8,  8,    0, 0, 0, 0,  0,            0, 0);
        vecs[2]  = v(1, 1, 5,  32'hDEADBEEF, 0, 0,  0,    1, 1, 0, 0,  0,            1, 32'h20);
        vecs[3]  = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 5,  32'hDEADBEEF, 0, 32'h20);
        vecs[4]  = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 0, 5,  32'hDEADBEEF, 0, 0);
        vecs[5]  = v(1, 1, 4,  32'h22,       1, 3,  32'h11, 1, 1, 0, 5, 32'hDEADBEEF, 2, 32'h18);
        vecs[6]  = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 3,  32'h11,       1, 32'h18);
        vecs[7]  = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 4,  32'h22,       0, 32'h10);
        vecs[8]  = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 0, 4,  32'h22,       0, 0);
        vecs[9]  = v(1, 1, 11, 11,           1, 10, 10,   1, 1, 0, 4,  32'h22,       2, 32'hC00);
        vecs[10] = v(1, 1, 13, 13,           1, 12, 12,   1, 1, 1, 10, 10,           3, 32'h3C00);
        vecs[11] = v(1, 1, 15, 15,           1, 14, 14,   0, 1, 1, 11, 11,           3, 32'h7800);
        vecs[12] = v(1, 1, 16, 16,           0, 0,  0,    1, 1, 1, 12, 12,           3, 32'h17000);
        vecs[13] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 13, 13,           2, 32'h16000);
        vecs[14] = v(1, 1, 0,  32'hFFFFFFFF, 0, 0,  0,    1, 1, 1, 14, 14,           1, 32'h14000);
        vecs[15] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 16, 16,           0, 32'h10000);
        vecs[16] = v(1, 1, 0,  32'hFFFFFFFF, 0, 0,  0,    1, 1, 0, 16, 16,           0, 0);
        vecs[17] = v(1, 1, 7,  1,            0, 0,  0,    1, 1, 0, 16, 16,           1, 32'h80);
        vecs[18] = v(1, 1, 7,  2,            0, 0,  0,    1, 1, 1, 7,  1,            1, 32'h80);
        vecs[19] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 1, 7,  2,            0, 32'h80);
        vecs[20] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 0, 7,  2,            0, 0);
        vecs[21] = v(1, 1, 21, 32'h21,       1, 20, 32'h20, 1, 1, 0, 7, 2,           2, 32'h300000);
        vecs[22] = v(1, 1, 23, 32'h23,       1, 22, 32'h22, 1, 1, 1, 20, 32'h20,     3, 32'hF00000);
        vecs[23] = v(0, 1, 24, 32'h24,       0, 0,  0,    0, 0, 0, 0,  0,            0, 0);
        vecs[24] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 0, 0,  0,            0, 0);
        vecs[25] = v(1, 0, 0,  0,            0, 0,  0,    1, 1, 0, 0,  0,            0, 0);

        d2_rst_n = 1'b0;
        d2_drive(1'b0, 0, 1'b0, 0);

        for (int i = 0; i < NV; i++) begin
            cur  = i;
            rst_n = vecs[i].rst_n;
            av = vecs[i].av; ard = vecs[i].ard; adat = vecs[i].adat;
            mv = vecs[i].mv; mrd = vecs[i].mrd; mdat = vecs[i].mdat;
            #1;
            check("alu_ready", 32'(ar), 32'(vecs[i].e_ar));
            check("mem_ready", 32'(mr), 32'(vecs[i].e_mr));
            @(posedge Clk);
            #1;
            check("we",        32'(we_o),   32'(vecs[i].e_we));
            check("rd",        32'(rd_o),   32'(vecs[i].e_rd));
            check("in",        in_o,        vecs[i].e_in);
            check("count",     32'(cnt_o),  32'(vecs[i].e_cnt));
            check("full",      32'(full_o), 32'(vecs[i].e_cnt == 3'd4));
            check("empty",     32'(empty_o), 32'(vecs[i].e_cnt == 3'd0));
            check("busy_mask", busy_o,      bm(vecs[i].e_busy));
        end

        // DEPTH=2: fill to full, then one free slot with both sources valid.
        cur = 100;
        d2_rst_n = 1'b1;
        d2_drive(1'b1, 1, 1'b1, 2);
        #1;
        check("d2_mem_ready_empty", 32'(d2_mr), 32'd1);
        check("d2_alu_ready_empty", 32'(d2_ar), 32'd1);
        @(posedge Clk); #1;
        cur = 101;
        check("d2_count_full", 32'(d2_cnt), 32'd2);
        check("d2_full",       32'(d2_full), 32'd1);
        check("d2_we_idle",    32'(d2_we), 32'd0);
        check("d2_busy_full",  d2_busy, bm(32'h6));
        d2_drive(1'b1, 3, 1'b1, 4);
        #1;
        check("d2_mem_ready_full", 32'(d2_mr), 32'd0);
        check("d2_alu_ready_full", 32'(d2_ar), 32'd0);
        @(posedge Clk); #1;
        cur = 102;
        check("d2_we1", 32'(d2_we), 32'd1);
        check("d2_rd1", 32'(d2_rd), 32'd1);
        check("d2_cnt1", 32'(d2_cnt), 32'd1);
        #1;
        check("d2_mem_ready_one", 32'(d2_mr), 32'd1);
        check("d2_alu_ready_one", 32'(d2_ar), 32'd0);
        @(posedge Clk); #1;
        cur = 103;
        d2_drive(1'b0, 0, 1'b0, 0);
        check("d2_rd2",  32'(d2_rd), 32'd2);
        check("d2_in2",  d2_in, 32'd2);
        check("d2_cnt2", 32'(d2_cnt), 32'd1);
        @(posedge Clk); #1;
        cur = 104;
        check("d2_we3", 32'(d2_we), 32'd1);
        check("d2_rd3", 32'(d2_rd), 32'd3);
        check("d2_cnt3", 32'(d2_cnt), 32'd0);
        @(posedge Clk); #1;
        cur = 105;
        check("d2_we_end",    32'(d2_we), 32'd0);
        check("d2_empty_end", 32'(d2_empty), 32'd1);
        check("d2_rd_hold",   32'(d2_rd), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_initiator.md
# regfile_write_initiator

Write-port initiator for the 32x32 register file. Accepts result write requests from the ALU path and the memory-load path over valid/ready handshakes and buffers them in a small in-order FIFO. Issues at most one registered write per cycle on the register file's `we`/`rd`/`in` port. Also exports a pending-write mask that decode uses for hazard checks.

## Interface
- `DEPTH`, 4 — FIFO entries; a power of two, minimum 2.
- `DATA_W`, 32 — write data width.
- `Clk`  in  1  — rising-edge clock.
- `resetControl_n`  in  1  — synchronous, active-low reset.
- `alu_valid`  in  1  — ALU write request.
- `alu_rd`  in  5  — ALU destination register.
- `alu_data`  in  DATA_W  — ALU result.
- `alu_ready`  out  1  — ALU request accepted this cycle when `alu_valid` is also high.
- `mem_valid`  in  1  — load write request.
- `mem_rd`  in  5  — load destination register.
- `mem_data`  in  DATA_W  — load result.
- `mem_ready`  out  1  — load request accepted this cycle when `mem_valid` is also high.
- `we`  out  1  — register file write enable; registered.
- `rd`  out  5  — register file write address; registered.
- `in`  out  DATA_W  — register file write data; registered.
- `busy_mask`  out  32  — bit i set while a write to register i is pending.
- `count`  out  $clog2(DEPTH)+1  — current FIFO occupancy.
- `full`  out  1  — FIFO full.
- `empty`  out  1  — FIFO empty.

## Operation
- Reset, while `resetControl_n` is sampled low at a clock edge:
  - `we`=0, `rd`=0, `in`=0.
  - FIFO pointers and `count` cleared to 0.
- While `resetControl_n` is low, `alu_ready`=`mem_ready`=0. Requests presented in that window are not accepted.
- Combinational outputs: `full` = (count==DEPTH); `empty` = (count==0).
- Ready rules are based on the free slot count at cycle start only; a same-cycle pop does not add room.
  - `mem_ready` = free≥1.
  - `alu_ready` = free≥2, or (free≥1 and !`mem_valid`).
- Simultaneous acceptance: the load entry is enqueued ahead of the ALU entry, so the load is older.
- A handshake with rd==0 completes, but the request is discarded: it is not enqueued, not counted, and never reaches `we`.
- Pop: each cycle the FIFO is non-empty, the head entry is popped and registered onto `we`/`rd`/`in` with `we`=1. Otherwise `we`=0; `rd`/`in` hold their last values.
- Writes are issued strictly in acceptance order. Pushes and a pop in the same cycle update `count` by pushes−pop.
- `busy_mask` is combinational: OR of one-hot(rd) over all valid FIFO entries, plus one-hot(`rd`) when `we`=1. Bit 0 is always 0.
  - Duplicate pending writes to the same register keep the bit set until the last one has been issued.
- Pointers wrap modulo DEPTH.

## Timing
- Request accepted at edge E. If the FIFO was empty, `we`/`rd`/`in` are valid after edge E+1 and the register file commits at edge E+2.
- Minimum latency is 1 cycle from acceptance to `we`. Queueing adds one cycle per older entry.
- Sustained throughput is 1 write per cycle.
- The `busy_mask` bit rises after E and falls after E+2 (once the register file holds the value), provided no newer write to that register is pending.
- Reset asserted mid-operation flushes all queued writes: none are issued and `busy_mask` is 0 after the reset edge.

## Configuration
- `WB_BUSY_MASK_EN`
  - Defined: `busy_mask` behaves as specified above.
  - Undefined: `busy_mask` is tied to 32'h0 and the tracking logic is not built. Decode must then stall on its own hazard logic.

## Test plan
- Reset, then a single ALU request (rd=5, data=32'hDEADBEEF) on an empty FIFO -> `we`=1, `rd`=5, `in`=32'hDEADBEEF one cycle after acceptance. `busy_mask`[5] is 1 for exactly 2 cycles.
- Simultaneous mem (rd=3, 32'h11) and ALU (rd=4, 32'h22) requests with 4 free slots -> both accepted; writes issue rd=3 then rd=4 on consecutive cycles.
- Hold `we` stalled by continuous pushes until `count`=DEPTH -> `full`=1 and `mem_ready`=`alu_ready`=0. With 1 free slot and both sources valid, only mem is accepted.
- ALU request with rd=0, data=32'hFFFFFFFF -> `alu_ready`=1 and the handshake completes; `count` is unchanged, `we` stays 0, `busy_mask`=0.
- Two queued writes to rd=7 (values 1 then 2) -> `in`=1 then `in`=2; `busy_mask`[7] clears only after the second write is issued.
- Three entries queued, `resetControl_n` driven low for one edge -> `count`=0, `we`=0, `busy_mask`=0, and no queued write ever appears on `we`.
